tick_enable_gen: RTL and testbench

//   Upstream enable source for the 4-bit synchronous up-counter.

---
 rtl/tick_enable_gen_pkg.sv | 12 +
 rtl/tick_enable_gen_btn_conditioner.sv | 49 ++++
 rtl/tick_enable_gen.sv | 58 +++++
 tb/tb_tick_enable_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_enable_gen_pkg.sv
// tick_enable_gen_pkg: FSM state codes and default parameters shared by the tick generator and its benches
package tick_enable_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;
  localparam int PRESCALE_DIV_DEF = 1000;
  localparam int PRESCALE_W_DEF   = 10;
  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int DEBOUNCE_W_DEF   = 5;
endpackage

// File: rtl/tick_enable_gen_btn_conditioner.sv
// btn_conditioner: 2-flop synchroniser, debounce filter when DEBOUNCE_EN is defined, registered rise pulse
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int DEBOUNCE_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  logic s1_q, s2_q, prev_q, press_q, lvl;
  if (DEBOUNCE_CYC < 1 || (1 << DEBOUNCE_W) <= DEBOUNCE_CYC) begin : g_bad_cfg
    $error("btn_conditioner: DEBOUNCE_W too narrow for DEBOUNCE_CYC");
  end
`ifdef DEBOUNCE_EN
  logic deb_q, deb_d, hit;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  // the counter only runs while the synced level disagrees with the accepted one
  assign hit   = s2_q != deb_q && cnt_q == DEBOUNCE_W'(DEBOUNCE_CYC - 1);
  assign deb_d = hit ? s2_q : deb_q;
  assign cnt_d = (s2_q == deb_q || hit) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign lvl = deb_q;
`else
  assign lvl = s2_q;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      prev_q  <= lvl;
      press_q <= lvl & ~prev_q;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/tick_enable_gen.sv
// tick_enable_gen: run/step FSM and prescaler producing the one-cycle enable strobe t for the up-counter
// Build with DEBOUNCE_EN defined to debounce both buttons.
module tick_enable_gen
  import tick_enable_gen_pkg::*;
#(
  parameter int PRESCALE_DIV = PRESCALE_DIV_DEF,
  parameter int PRESCALE_W   = PRESCALE_W_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int DEBOUNCE_W   = DEBOUNCE_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic t,
  output logic running
);
  state_t state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic run_p, step_p, tc;
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DEBOUNCE_W(DEBOUNCE_W)) u_run (
    .clk(clk), .rst(rst), .btn_i(btn_run), .press_o(run_p)
  );
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DEBOUNCE_W(DEBOUNCE_W)) u_step (
    .clk(clk), .rst(rst), .btn_i(btn_step), .press_o(step_p)
  );
  assign tc = pre_q == PRESCALE_W'(PRESCALE_DIV - 1);
  // outputs decode only flops (state, prescaler, registered press pulses)
  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    t       = 1'b0;
    running = 1'b0;
    case (state_q)
      ST_IDLE: state_d = run_p ? ST_RUN : (step_p ? ST_STEP : ST_IDLE);
      ST_STEP: begin
        state_d = ST_IDLE;
        t       = 1'b1;
      end
      ST_RUN: begin
        running = 1'b1;
        t       = tc & ~run_p;
        state_d = run_p ? ST_IDLE : ST_RUN;
        pre_d   = (run_p | tc) ? '0 : pre_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end
endmodule

// File: tb/tb_tick_enable_gen.sv
// tb_tick_enable_gen: scoreboard bench for tick_enable_gen (PRESCALE_DIV=4, DEBOUNCE_CYC=3), with or without DEBOUNCE_EN
module tb_tick_enable_gen;
  localparam int DIV = 4;
  localparam int DCYC = 3;
`ifdef DEBOUNCE_EN
  localparam int PL = 3 + DCYC;
`else
  localparam int PL = 3;
`endif
  logic clk = 1'b0;
  logic rst, btn_run, btn_step;
  logic t, running;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e;
  logic [3:0] cnt4 = 4'd0;
  int exp_q[$];

  tick_enable_gen #(.PRESCALE_DIV(DIV), .PRESCALE_W(2), .DEBOUNCE_CYC(DCYC), .DEBOUNCE_W(3)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .t(t), .running(running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (t) begin
      cnt4 = cnt4 + 4'd1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL t_unexpected: t=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL t_cycle: t=1 at cycle %0d, expected pulse at cycle %0d", cyc, e);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL t_missed: t=0 at cycle %0d, expected pulse at cycle %0d", cyc, e);
    end
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk_run(input string name, input logic exp);
    checks++;
    if (running !== exp) begin
      errors++;
      $display("FAIL %s: running=%b at cycle %0d, expected %b", name, running, cyc, exp);
    end
  endtask

  task automatic chk_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses outstanding at cycle %0d, expected 0", name, exp_q.size(), cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      btn_run = 1'($urandom_range(0, 1));
      btn_step = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (t !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: t=%b running=%b at cycle %0d, expected 0 0", t, running, cyc);
      end
    end
    btn_run = 1'b0;
    btn_step = 1'b0;
    rst = 1'b1;
    tick_until(cyc + 6);
    chk_run("reset_idle", 1'b0);
  endtask

  task automatic test_step();
    int k = cyc;
    btn_step = 1'b1;
    exp_q.push_back(k + PL + 1);
    tick_until(k + 20);
    btn_step = 1'b0;
    tick_until(k + 32);
    chk_empty("step_pending");
    chk_run("step_running", 1'b0);
    checks++;
    if (cnt4 !== 4'd1) begin
      errors++;
      $display("FAIL step_count: count=%0d, expected 1", cnt4);
    end
  endtask

  task automatic test_run(output int last);
    int k = cyc;
    btn_run = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(k + PL + DIV + DIV * i);
    last = k + PL + DIV + DIV * 15;
    tick_until(k + PL);
    chk_run("run_not_yet", 1'b0);
    tick();
    chk_run("run_entered", 1'b1);
    tick_until(k + 6);
    btn_run = 1'b0;
    tick_until(last - DIV);
    checks++;
    if (cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL run_wrap: count=%0d after 15 ticks, expected 0", cnt4);
    end
    tick_until(last);
    checks++;
    if (cnt4 !== 4'd1) begin
      errors++;
      $display("FAIL run_count: count=%0d after 16 ticks, expected 1", cnt4);
    end
    chk_run("run_still", 1'b1);
  endtask

  task automatic test_stop(input int last);
    int x = last + 2 * DIV;
    exp_q.push_back(last + DIV);
    tick_until(x - PL);
    btn_run = 1'b1;
    tick_until(x);
    checks++;
    if (t !== 1'b0) begin
      errors++;
      $display("FAIL stop_suppress: t=%b at terminal stop cycle %0d, expected 0", t, cyc);
    end
    chk_run("stop_cycle_running", 1'b1);
    tick();
    chk_run("stop_idle", 1'b0);
    tick_until(x - PL + 6);
    btn_run = 1'b0;
    tick_until(x + 14);
    chk_run("stop_stays_idle", 1'b0);
    chk_empty("stop_pending");
  endtask

  task automatic test_glitch();
    int k = cyc;
    logic [3:0] c0 = cnt4;
    btn_step = 1'b1;
`ifndef DEBOUNCE_EN
    exp_q.push_back(k + 4);
`endif
    tick_until(k + 2);
    btn_step = 1'b0;
    tick_until(k + 20);
    chk_empty("glitch_pending");
    checks++;
`ifdef DEBOUNCE_EN
    if (cnt4 !== c0) begin
      errors++;
      $display("FAIL glitch_filtered: count=%0d, expected %0d", cnt4, c0);
    end
`else
    if (cnt4 !== c0 + 4'd1) begin
      errors++;
      $display("FAIL glitch_passed: count=%0d, expected %0d", cnt4, c0 + 4'd1);
    end
`endif
  endtask

  task automatic test_both_and_reset();
    int k = cyc;
    btn_run = 1'b1;
    btn_step = 1'b1;
    exp_q.push_back(k + PL + DIV);
    exp_q.push_back(k + PL + 2 * DIV);
    tick_until(k + PL + 1);
    chk_run("both_run_wins", 1'b1);
    btn_run = 1'b0;
    btn_step = 1'b0;
    tick_until(k + PL + 3 * DIV - 1);
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (t !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: t=%b running=%b, expected 0 0", t, running);
    end
    tick();
    tick();
    chk_run("reset_held", 1'b0);
    rst = 1'b1;
    tick_until(cyc + 10);
    chk_run("after_reset_idle", 1'b0);
    chk_empty("final_pending");
  endtask

  initial begin
    int last;
    test_reset();
    test_step();
    test_run(last);
    test_stop(last);
    test_glitch();
    test_both_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
